axi_cache_line_master: RTL

AXI4 full master that moves whole cache lines for the pipelined CPU's cache/TLB subsystem. It turns one line-refill (read) or line-writeback (write) request from the cache controller into a single INCR burst, and collects or streams the beats. It sits between the cache controller and the AXI4 memory slave (RAM model or interconnect). At most one transaction is in flight at a time.

---
 rtl/axi_pkg.sv | 43 ++++
 rtl/axi_cache_line_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, burst helpers and the cache-line master FSM state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_RESP
    } mst_state_t;

    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

    // Address of the beat following addr within a burst of (len+1) beats.
    function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                  input logic [2:0]  size,
                                                  input logic [1:0]  burst,
                                                  input logic [7:0]  len);
        logic [63:0] step;
        logic [63:0] wrap_bytes;
        step       = 64'd1 << size;
        wrap_bytes = (64'(len) + 64'd1) << size;
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~(wrap_bytes - 64'd1)) | ((addr + step) & (wrap_bytes - 64'd1));
            default:     return addr + step;
        endcase
    endfunction

endpackage

// File: rtl/axi_cache_line_master.sv
// AXI4 master turning one line refill/writeback into a single INCR burst, one transaction at a time.
// Request handshake to AR/AW VALID is 1 cycle; every channel holds VALID and payload until READY.
module axi_cache_line_master
    import axi_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ID         = 0,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int LINE_WORDS         = 4
) (
    input  logic                                       S_AXI_ACLK,
    input  logic                                       rst,
    input  logic                                       req_rd_valid,
    output logic                                       req_rd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]              req_rd_addr,
    output logic                                       resp_rd_valid,
    output logic [LINE_WORDS*C_M_AXI_DATA_WIDTH-1:0]   resp_rd_data,
    input  logic                                       req_wr_valid,
    output logic                                       req_wr_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]              req_wr_addr,
    input  logic [LINE_WORDS*C_M_AXI_DATA_WIDTH-1:0]   req_wr_data,
    output logic                                       resp_wr_done,
    output logic                                       resp_err,
    output logic [C_M_AXI_ID_WIDTH-1:0]                M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]              M_AXI_ARADDR,
    output logic [7:0]                                 M_AXI_ARLEN,
    output logic [2:0]                                 M_AXI_ARSIZE,
    output logic [1:0]                                 M_AXI_ARBURST,
    output logic                                       M_AXI_ARLOCK,
    output logic [3:0]                                 M_AXI_ARCACHE,
    output logic [2:0]                                 M_AXI_ARPROT,
    output logic [3:0]                                 M_AXI_ARQOS,
    output logic [3:0]                                 M_AXI_ARREGION,
    output logic                                       M_AXI_ARVALID,
    input  logic                                       M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]                M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]              M_AXI_RDATA,
    input  logic [1:0]                                 M_AXI_RRESP,
    input  logic                                       M_AXI_RLAST,
    input  logic                                       M_AXI_RVALID,
    output logic                                       M_AXI_RREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]                M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]              M_AXI_AWADDR,
    output logic [7:0]                                 M_AXI_AWLEN,
    output logic [2:0]                                 M_AXI_AWSIZE,
    output logic [1:0]                                 M_AXI_AWBURST,
    output logic                                       M_AXI_AWLOCK,
    output logic [3:0]                                 M_AXI_AWCACHE,
    output logic [2:0]                                 M_AXI_AWPROT,
    output logic [3:0]                                 M_AXI_AWQOS,
    output logic [3:0]                                 M_AXI_AWREGION,
    output logic                                       M_AXI_AWVALID,
    input  logic                                       M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]              M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]            M_AXI_WSTRB,
    output logic                                       M_AXI_WLAST,
    output logic                                       M_AXI_WVALID,
    input  logic                                       M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]                M_AXI_BID,
    input  logic [1:0]                                 M_AXI_BRESP,
    input  logic                                       M_AXI_BVALID,
    output logic                                       M_AXI_BREADY
);

    localparam int DW         = C_M_AXI_DATA_WIDTH;
    localparam int LINE_W     = LINE_WORDS * DW;
    localparam int IDX_W      = $clog2(LINE_WORDS);
    localparam int CNT_W      = IDX_W + 1;
    localparam logic [CNT_W-1:0]              LAST_CNT  = CNT_W'(LINE_WORDS - 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] LINE_MASK = C_M_AXI_ADDR_WIDTH'(LINE_W / 8 - 1);
    localparam logic [C_M_AXI_ID_WIDTH-1:0]   ID_VAL    = C_M_AXI_ID_WIDTH'(C_M_AXI_ID);

    mst_state_t                    state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]             wr_line_q, wr_line_d;
    logic [LINE_W-1:0]             rd_line_q, rd_line_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          err_q, err_d;
    logic                          is_rd_q, is_rd_d;

    logic [IDX_W-1:0] idx;
    logic             cnt_last;
    logic             wr_hs;
    logic             rd_hs;

    assign idx      = cnt_q[IDX_W-1:0];
    assign cnt_last = (cnt_q == LAST_CNT);
    assign wr_hs    = req_wr_valid && req_wr_ready;
    assign rd_hs    = req_rd_valid && req_rd_ready;

    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_line_q <= '0;
            rd_line_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            is_rd_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_line_q <= wr_line_d;
            rd_line_q <= rd_line_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            is_rd_q   <= is_rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_line_d = wr_line_q;
        rd_line_d = rd_line_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        is_rd_d   = is_rd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_hs) begin
                    addr_d    = req_wr_addr & ~LINE_MASK;
                    wr_line_d = req_wr_data;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    is_rd_d   = 1'b0;
                    state_d   = ST_AW;
                end else if (rd_hs) begin
                    addr_d  = req_rd_addr & ~LINE_MASK;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    is_rd_d = 1'b1;
                    state_d = ST_AR;
                end
            end
            ST_AR: if (M_AXI_ARREADY) state_d = ST_R;
            ST_R: begin
                // The beat count alone ends the burst; a misplaced RLAST only flags an error.
                if (M_AXI_RVALID) begin
                    rd_line_d[int'(idx)*DW +: DW] = M_AXI_RDATA;
                    if (M_AXI_RRESP != RESP_OKAY || M_AXI_RID != ID_VAL || M_AXI_RLAST != cnt_last)
                        err_d = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_last) state_d = ST_RESP;
                end
            end
            ST_AW: if (M_AXI_AWREADY) state_d = ST_W;
            ST_W: begin
                if (M_AXI_WREADY) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_last) state_d = ST_B;
                end
            end
            ST_B: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != RESP_OKAY || M_AXI_BID != ID_VAL) err_d = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_wr_ready  = 1'b0;
        req_rd_ready  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        resp_rd_valid = 1'b0;
        resp_wr_done  = 1'b0;
        resp_err      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_wr_ready = !rst;
                req_rd_ready = !rst && !req_wr_valid;
            end
            ST_AR:   M_AXI_ARVALID = 1'b1;
            ST_R:    M_AXI_RREADY  = 1'b1;
            ST_AW:   M_AXI_AWVALID = 1'b1;
            ST_W: begin
                M_AXI_WVALID = 1'b1;
                M_AXI_WLAST  = cnt_last;
            end
            ST_B:    M_AXI_BREADY  = 1'b1;
            ST_RESP: begin
                resp_rd_valid = is_rd_q;
                resp_wr_done  = !is_rd_q;
                resp_err      = err_q;
            end
            default: ;
        endcase
    end

    assign resp_rd_data = rd_line_q;
    assign M_AXI_WDATA  = wr_line_q[int'(idx)*DW +: DW];
    assign M_AXI_WSTRB  = '1;

    assign M_AXI_ARID     = ID_VAL;
    assign M_AXI_ARADDR   = addr_q;
    assign M_AXI_ARLEN    = 8'(LINE_WORDS - 1);
    assign M_AXI_ARSIZE   = axi_size(DW);
    assign M_AXI_ARBURST  = BURST_INCR;
    assign M_AXI_ARLOCK   = 1'b0;
    assign M_AXI_ARCACHE  = 4'd0;
    assign M_AXI_ARPROT   = 3'd0;
    assign M_AXI_ARQOS    = 4'd0;
    assign M_AXI_ARREGION = 4'd0;

    assign M_AXI_AWID     = ID_VAL;
    assign M_AXI_AWADDR   = addr_q;
    assign M_AXI_AWLEN    = 8'(LINE_WORDS - 1);
    assign M_AXI_AWSIZE   = axi_size(DW);
    assign M_AXI_AWBURST  = BURST_INCR;
    assign M_AXI_AWLOCK   = 1'b0;
    assign M_AXI_AWCACHE  = 4'd0;
    assign M_AXI_AWPROT   = 3'd0;
    assign M_AXI_AWQOS    = 4'd0;
    assign M_AXI_AWREGION = 4'd0;

endmodule
